// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the MIPS fetch PC sequencer: default vectors,
// redirect-select encoding and the branch-offset helper.
package mips_pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_HOLD = 3'd1,
    SEL_BR   = 3'd2,
    SEL_J    = 3'd3,
    SEL_JR   = 3'd4,
    SEL_ERET = 3'd5,
    SEL_EXC  = 3'd6
  } sel_e;

  // Word offset field to a sign-extended byte offset.
  function automatic logic [31:0] sext_shift(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/redirect bundle between the PC sequencer (master) and its
// imem / pipeline neighbours (slave).
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_out;
  logic              pc_valid;
  logic              pc_ready;
  logic [ADDR_W-1:0] src_pc;
  logic              br_taken;
  logic [15:0]       br_imm;
  logic              j_en;
  logic [25:0]       j_target;
  logic              jr_en;
  logic [ADDR_W-1:0] jr_addr;
  logic              exc;
  logic              eret;
  logic              link;
  logic [ADDR_W-1:0] epc;
  logic              flush;
  logic              addr_err;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_valid;

  modport master (
    output pc_out, pc_valid, epc, flush, addr_err, ras_top, ras_valid,
    input  pc_ready, src_pc, br_taken, br_imm, j_en, j_target,
           jr_en, jr_addr, exc, eret, link
  );

  modport slave (
    input  pc_out, pc_valid, epc, flush, addr_err, ras_top, ras_valid,
    output pc_ready, src_pc, br_taken, br_imm, j_en, j_target,
           jr_en, jr_addr, exc, eret, link
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry,
// underflowing pops are ignored. Top and valid are registered.
module pc_ras #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_valid
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_top;
  logic              r_valid;

  // r_ptr is the next write slot; the live top sits one below it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_top   <= '0;
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_mem[r_ptr] <= i_data;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (r_cnt != CNT_W'(DEPTH)) r_cnt <= r_cnt + CNT_W'(1);
      r_top        <= i_data;
      r_valid      <= 1'b1;
    end else if (i_pop && (r_cnt != '0)) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_cnt   <= r_cnt - CNT_W'(1);
      r_top   <= (r_cnt == CNT_W'(1)) ? '0 : r_mem[r_ptr - PTR_W'(2)];
      r_valid <= (r_cnt != CNT_W'(1));
    end
  end

  assign o_top   = r_top;
  assign o_valid = r_valid;

endmodule

// File: rtl/pc_sequencer.sv
// MIPS fetch program counter with prioritised redirects, EPC and
// misaligned-JR reporting. Optional return-address stack under PC_RAS_EN.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic [ADDR_W-1:0] r_epc;
  logic              r_flush;
  logic              r_aerr;

  sel_e              w_sel;
  logic [ADDR_W-1:0] w_next;
  logic              w_aerr;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_j_tgt;
  logic [ADDR_W-1:0] w_jr_tgt;

  assign w_base   = bus.src_pc + ADDR_W'(4);
  assign w_br_tgt = w_base + ADDR_W'($signed(sext_shift(bus.br_imm)));
  assign w_j_tgt  = {w_base[ADDR_W-1:28], bus.j_target, 2'b00};
  assign w_jr_tgt = {bus.jr_addr[ADDR_W-1:2], 2'b00};

  // Redirect priority: exc > eret > jr > j > branch, independent of pc_ready.
  always_comb begin
    w_sel  = SEL_HOLD;
    w_next = r_pc;
    w_aerr = 1'b0;
    if (bus.exc) begin
      w_sel  = SEL_EXC;
      w_next = EXC_VEC;
    end else if (bus.eret) begin
      w_sel  = SEL_ERET;
      w_next = r_epc;
    end else if (bus.jr_en) begin
      w_sel  = SEL_JR;
      w_next = w_jr_tgt;
      w_aerr = |bus.jr_addr[1:0];
    end else if (bus.j_en) begin
      w_sel  = SEL_J;
      w_next = w_j_tgt;
    end else if (bus.br_taken) begin
      w_sel  = SEL_BR;
      w_next = w_br_tgt;
    end else if (r_valid && bus.pc_ready) begin
      w_sel  = SEL_SEQ;
      w_next = r_pc + ADDR_W'(4);
    end
  end

  assign w_redirect = (w_sel != SEL_SEQ) && (w_sel != SEL_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
      r_epc   <= '0;
      r_flush <= 1'b0;
      r_aerr  <= 1'b0;
    end else begin
      r_pc    <= w_next & ~ADDR_W'(3);
      r_valid <= 1'b1;
      r_flush <= w_redirect;
      r_aerr  <= w_aerr;
      if (w_sel == SEL_EXC) r_epc <= bus.src_pc;
    end
  end

  assign bus.pc_out   = r_pc;
  assign bus.pc_valid = r_valid;
  assign bus.epc      = r_epc;
  assign bus.flush    = r_flush;
  assign bus.addr_err = r_aerr;

`ifdef PC_RAS_EN
  logic w_push;
  logic w_pop;

  // exc always wins selection, so pushes/pops are already blocked under it.
  assign w_push = ((w_sel == SEL_JR) || (w_sel == SEL_J)) && bus.link;
  assign w_pop  = (w_sel == SEL_JR) && !bus.link;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_base),
    .o_top   (bus.ras_top),
    .o_valid (bus.ras_valid)
  );
`else
  logic [1:0] w_unused_ras;
  assign w_unused_ras  = {bus.link, RAS_DEPTH == 0};
  assign bus.ras_top   = '0;
  assign bus.ras_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a behavioural model. Honours PC_RAS_EN.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W    = 32;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0180;
  localparam int          RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) u_if ();

  pc_sequencer #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (RESET_VEC),
    .EXC_VEC   (EXC_VEC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_epc;
  logic        m_flush;
  logic        m_aerr;
  logic [31:0] m_ras[$];

  function automatic void model_reset();
    m_pc = RESET_VEC; m_valid = 1'b0; m_epc = '0;
    m_flush = 1'b0; m_aerr = 1'b0;
    m_ras.delete();
  endfunction

  function automatic void model_step();
    logic [31:0] base;
    base    = u_if.src_pc + 32'd4;
    m_flush = u_if.exc | u_if.eret | u_if.jr_en | u_if.j_en | u_if.br_taken;
    m_aerr  = 1'b0;
    if (u_if.exc) begin
      m_pc  = EXC_VEC;
      m_epc = u_if.src_pc;
    end else if (u_if.eret) begin
      m_pc = m_epc & ~32'd3;
    end else if (u_if.jr_en) begin
      m_pc   = u_if.jr_addr & ~32'd3;
      m_aerr = (u_if.jr_addr % 4) != 0;
`ifdef PC_RAS_EN
      if (u_if.link) begin
        m_ras.push_back(base);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
`endif
    end else if (u_if.j_en) begin
      m_pc = (base & 32'hF000_0000) | (32'(u_if.j_target) * 4);
`ifdef PC_RAS_EN
      if (u_if.link) begin
        m_ras.push_back(base);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
`endif
    end else if (u_if.br_taken) begin
      m_pc = (base + 32'(int'($signed(u_if.br_imm)) * 4)) & ~32'd3;
    end else if (m_valid && u_if.pc_ready) begin
      m_pc = m_pc + 32'd4;
    end
    m_valid = 1'b1;
  endfunction

  task automatic clear_inputs();
    u_if.pc_ready = 1'b1; u_if.src_pc = '0;
    u_if.br_taken = 1'b0; u_if.br_imm = '0;
    u_if.j_en = 1'b0; u_if.j_target = '0;
    u_if.jr_en = 1'b0; u_if.jr_addr = '0;
    u_if.exc = 1'b0; u_if.eret = 1'b0; u_if.link = 1'b0;
  endtask

  // One clock: advance the model with the current inputs, sample 1ns after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (u_if.pc_valid !== 1'b0 || u_if.pc_out !== RESET_VEC) begin
      n_errors++;
      $display("FAIL reset_pc: valid=%b pc=%h, required valid=0 pc=%h", u_if.pc_valid, u_if.pc_out, RESET_VEC);
    end
    n_checks++;
    if (u_if.epc !== 32'd0 || u_if.flush !== 1'b0 || u_if.addr_err !== 1'b0 ||
        u_if.ras_valid !== 1'b0 || u_if.ras_top !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_misc: epc=%h flush=%b aerr=%b rv=%b rt=%h, required all 0",
               u_if.epc, u_if.flush, u_if.addr_err, u_if.ras_valid, u_if.ras_top);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (u_if.pc_valid !== 1'b1 || u_if.pc_out !== 32'd0) begin
      n_errors++;
      $display("FAIL release: valid=%b pc=%h, required valid=1 pc=0", u_if.pc_valid, u_if.pc_out);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (u_if.pc_out !== 32'(4 * k)) begin
        n_errors++;
        $display("FAIL seq_%0d: pc=%h, required %h", k, u_if.pc_out, 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h10) begin
      n_errors++;
      $display("FAIL pre_stall: pc=%h, required 10", u_if.pc_out);
    end
    u_if.pc_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (u_if.pc_out !== 32'h10 || u_if.flush !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_%0d: pc=%h flush=%b, required pc=10 flush=0", k, u_if.pc_out, u_if.flush);
      end
    end
    u_if.br_taken = 1'b1; u_if.src_pc = 32'h40; u_if.br_imm = 16'd3;
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h50 || u_if.flush !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_branch: pc=%h flush=%b, required pc=50 flush=1", u_if.pc_out, u_if.flush);
    end
    clear_inputs();
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h54 || u_if.flush !== 1'b0) begin
      n_errors++;
      $display("FAIL post_branch: pc=%h flush=%b, required pc=54 flush=0", u_if.pc_out, u_if.flush);
    end
  endtask

  task automatic test_branch_back();
    u_if.br_taken = 1'b1; u_if.src_pc = 32'h100; u_if.br_imm = 16'hFFFE;
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h0FC || u_if.flush !== 1'b1) begin
      n_errors++;
      $display("FAIL branch_back: pc=%h flush=%b, required pc=0fc flush=1", u_if.pc_out, u_if.flush);
    end
    clear_inputs();
  endtask

  task automatic test_exc_eret();
    u_if.exc = 1'b1; u_if.jr_en = 1'b1; u_if.j_en = 1'b1;
    u_if.jr_addr = 32'h3003; u_if.j_target = 26'h3FF; u_if.src_pc = 32'h200;
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h180 || u_if.epc !== 32'h200 || u_if.addr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL exc_prio: pc=%h epc=%h aerr=%b, required pc=180 epc=200 aerr=0",
               u_if.pc_out, u_if.epc, u_if.addr_err);
    end
    clear_inputs();
    step();
    u_if.eret = 1'b1;
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h200 || u_if.flush !== 1'b1) begin
      n_errors++;
      $display("FAIL eret: pc=%h flush=%b, required pc=200 flush=1", u_if.pc_out, u_if.flush);
    end
    u_if.exc = 1'b1; u_if.eret = 1'b1; u_if.src_pc = 32'h300;
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h180 || u_if.epc !== 32'h300) begin
      n_errors++;
      $display("FAIL exc_eret: pc=%h epc=%h, required pc=180 epc=300", u_if.pc_out, u_if.epc);
    end
    clear_inputs();
  endtask

  task automatic test_jr_misalign();
    u_if.jr_en = 1'b1; u_if.jr_addr = 32'h1003;
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h1000 || u_if.addr_err !== 1'b1) begin
      n_errors++;
      $display("FAIL jr_misalign: pc=%h aerr=%b, required pc=1000 aerr=1", u_if.pc_out, u_if.addr_err);
    end
    clear_inputs();
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h1004 || u_if.addr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL aerr_pulse: pc=%h aerr=%b, required pc=1004 aerr=0", u_if.pc_out, u_if.addr_err);
    end
  endtask

  task automatic test_wrap();
    u_if.jr_en = 1'b1; u_if.jr_addr = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    step();
    n_checks++;
    if (u_if.pc_out !== 32'h0 || u_if.addr_err !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap: pc=%h aerr=%b, required pc=0 aerr=0", u_if.pc_out, u_if.addr_err);
    end
  endtask

  task automatic test_ras();
    logic [31:0] exp_top;
    for (int i = 0; i < 5; i++) begin
      u_if.j_en = 1'b1; u_if.link = 1'b1; u_if.j_target = 26'h40;
      u_if.src_pc = 32'(16 * i);
      step();
    end
    clear_inputs();
`ifdef PC_RAS_EN
    for (int k = 0; k < 4; k++) begin
      exp_top = 32'h44 - 32'(16 * k);
      n_checks++;
      if (u_if.ras_valid !== 1'b1 || u_if.ras_top !== exp_top) begin
        n_errors++;
        $display("FAIL ras_pop_%0d: valid=%b top=%h, required valid=1 top=%h",
                 k, u_if.ras_valid, u_if.ras_top, exp_top);
      end
      u_if.jr_en = 1'b1; u_if.link = 1'b0; u_if.jr_addr = 32'h500;
      step();
    end
    n_checks++;
    if (u_if.ras_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ras_empty: valid=%b, required 0", u_if.ras_valid);
    end
    step();
    n_checks++;
    if (u_if.ras_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ras_underflow: valid=%b, required 0", u_if.ras_valid);
    end
`else
    exp_top = 32'd0;
    n_checks++;
    if (u_if.ras_valid !== 1'b0 || u_if.ras_top !== exp_top) begin
      n_errors++;
      $display("FAIL ras_off: valid=%b top=%h, required valid=0 top=0", u_if.ras_valid, u_if.ras_top);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] exp_top;
    for (int n = 0; n < 400; n++) begin
      u_if.pc_ready = ($urandom_range(3) != 0);
      u_if.src_pc   = $urandom() & (($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      u_if.br_imm   = 16'($urandom());
      u_if.j_target = 26'($urandom());
      u_if.jr_addr  = $urandom();
      u_if.br_taken = ($urandom_range(5) == 0);
      u_if.j_en     = ($urandom_range(7) == 0);
      u_if.jr_en    = ($urandom_range(7) == 0);
      u_if.eret     = ($urandom_range(15) == 0);
      u_if.exc      = ($urandom_range(19) == 0);
      u_if.link     = $urandom_range(1) != 0;
      step();
      n_checks++;
      if (u_if.pc_out !== m_pc || u_if.pc_valid !== m_valid || u_if.flush !== m_flush ||
          u_if.addr_err !== m_aerr || u_if.epc !== m_epc) begin
        n_errors++;
        $display("FAIL rand_%0d: pc=%h v=%b fl=%b ae=%b epc=%h, required pc=%h v=%b fl=%b ae=%b epc=%h",
                 n, u_if.pc_out, u_if.pc_valid, u_if.flush, u_if.addr_err, u_if.epc,
                 m_pc, m_valid, m_flush, m_aerr, m_epc);
      end
      exp_top = (m_ras.size() > 0) ? m_ras[$] : 32'd0;
      n_checks++;
      if (u_if.ras_valid !== (m_ras.size() > 0) ||
          (m_ras.size() > 0 && u_if.ras_top !== exp_top)) begin
        n_errors++;
        $display("FAIL rand_ras_%0d: valid=%b top=%h, required valid=%b top=%h",
                 n, u_if.ras_valid, u_if.ras_top, m_ras.size() > 0, exp_top);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    u_if.br_taken = 1'b1; u_if.src_pc = 32'h800; u_if.br_imm = 16'h10;
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (u_if.pc_out !== RESET_VEC || u_if.pc_valid !== 1'b0 || u_if.ras_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: pc=%h v=%b rv=%b, required pc=%h v=0 rv=0",
               u_if.pc_out, u_if.pc_valid, u_if.ras_valid, RESET_VEC);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    reset = 1'b0;
    step();
    n_checks++;
    if (u_if.pc_out !== RESET_VEC || u_if.flush !== 1'b0 || u_if.pc_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_release: pc=%h fl=%b v=%b, required pc=%h fl=0 v=1",
               u_if.pc_out, u_if.flush, u_if.pc_valid, RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch_back();
    test_exc_eret();
    test_jr_misalign();
    test_wrap();
    test_ras();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
